// File: rtl/wcm_pkg.sv
// Shared types, parameter defaults and helpers for the word clock multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package wcm_pkg;

    localparam int DIVW_DEF     = 16;
    localparam int MULTW_DEF    = 8;
    localparam int LOCK_TOL_DEF = 4;
    localparam int LOCK_CNT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2,
        HOLD = 2'd3
    } wcm_state_t;

    // Unsigned absolute difference, used for word-to-word period deviation.
    function automatic logic [31:0] wcm_absdiff(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/word_clock_multiplier_if.sv
// Word clock in / bit clock out bundle of the word clock multiplier.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are free-running levels or pulses.
interface word_clock_multiplier_if
    import wcm_pkg::*;
#(
    parameter int DIVW  = DIVW_DEF,
    parameter int MULTW = MULTW_DEF
);
    logic             wc;
    logic             holdover_en;
    logic             bitclock;
    logic             bit_strobe;
    logic [MULTW-1:0] bit_index;
    logic             locked;
    logic [DIVW:0]    period;
    logic             slip;

    // Word clock source / bit clock consumer side.
    modport master (
        output wc, holdover_en,
        input  bitclock, bit_strobe, bit_index, locked, period, slip
    );

    // Multiplier side.
    modport slave (
        input  wc, holdover_en,
        output bitclock, bit_strobe, bit_index, locked, period, slip
    );

endinterface

// File: rtl/wcm_phase_acc.sv
// Phase accumulator: spreads N strobes evenly over a period of P clk cycles.
// Latency: strobe/bitclock are combinational views of the next accumulator state.
// Backpressure: none; runs every cycle while enabled.
module wcm_phase_acc #(
    parameter int DIVW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          restart,
    input  logic [DIVW:0] p,
    input  logic [DIVW:0] n,
    output logic          strobe,
    output logic          bitclock
);
    typedef logic [DIVW:0] acc_t;

    acc_t            acc_q;
    acc_t            acc_d;
    logic [DIVW+1:0] sum;

    // Advance the accumulator by N per cycle, wrapping by P and flagging a strobe.
    always_comb begin
        acc_d  = acc_q;
        strobe = 1'b0;
        sum    = {1'b0, acc_q} + {1'b0, n};
        if (!en) begin
            acc_d = '0;
        end else if (restart) begin
            acc_d  = '0;
            strobe = 1'b1;
        end else if (sum >= {1'b0, p}) begin
            acc_d  = acc_t'(sum - {1'b0, p});
            strobe = 1'b1;
        end else begin
            acc_d = acc_t'(sum);
        end
        bitclock = en && (acc_d < (p >> 1));
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/word_clock_multiplier.sv
// Word clock multiplier: measures the wc period and emits N=2^MULTW bit strobes per word.
// Latency: first strobe one cycle after the wc rising edge; all outputs registered.
// Backpressure: none; holdover free-runs on the last accepted period when wc is lost.
module word_clock_multiplier
    import wcm_pkg::*;
#(
    parameter int DIVW     = DIVW_DEF,
    parameter int MULTW    = MULTW_DEF,
    parameter int LOCK_TOL = LOCK_TOL_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input logic                     clk,
    input logic                     reset,
    word_clock_multiplier_if.slave  bus
);
    localparam int GW = $clog2(LOCK_CNT + 1);

    typedef logic [DIVW:0]  cnt_t;
    typedef logic [GW-1:0]  good_t;
    typedef logic [MULTW-1:0] idx_t;

    localparam cnt_t  N_VAL    = cnt_t'(1) << MULTW;
    localparam cnt_t  CNT_MAX  = '1;
    localparam idx_t  IDX_LAST = '1;
    localparam good_t GOOD_MAX = good_t'(LOCK_CNT);

    wcm_state_t state_q, state_d;
    logic       wc_d_q;
    cnt_t       cnt_q, cnt_d;
    cnt_t       period_q, period_d;
    cnt_t       prev_q, prev_d;
    logic       have_prev_q, have_prev_d;
    logic       gen_ok_q, gen_ok_d;
    good_t      good_q, good_d;
    logic       bitclock_q, bitclock_d;
    logic       bit_strobe_q, bit_strobe_d;
    idx_t       bit_index_q, bit_index_d;
    logic       locked_q, locked_d;
    logic       slip_q, slip_d;

    logic        wc_rise;
    logic        cnt_sat;
    logic        measuring;
    logic        p_good;
    logic        timeout;
    logic        restart;
    logic        gen_en;
    logic        gen_strobe;
    logic        gen_bitclock;
    logic [31:0] p_diff;

    assign wc_rise   = bus.wc & ~wc_d_q;
    assign cnt_sat   = (cnt_q == CNT_MAX);
    assign measuring = (state_q == ACQ) || (state_q == LOCK);
    assign p_diff    = wcm_absdiff(32'(cnt_q), 32'(prev_q));
    // The first period after a measurement start has nothing to compare against.
    assign p_good    = (cnt_q >= N_VAL) && !cnt_sat &&
                       (!have_prev_q || (p_diff <= 32'(LOCK_TOL)));
    // Without an accepted period there is no 2P reference; fall back to saturation.
    assign timeout   = gen_ok_q ? ({1'b0, cnt_q} > {period_q, 1'b0}) : cnt_sat;

    // Period measurement, lock qualification and state transitions; an edge wins over a timeout.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        period_d    = period_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        gen_ok_d    = gen_ok_q;
        good_d      = good_q;
        slip_d      = 1'b0;
        restart     = 1'b0;
        if (wc_rise) begin
            restart = 1'b1;
            cnt_d   = cnt_t'(1);
            if ((state_q != IDLE) && gen_ok_q && (bit_index_q != IDX_LAST)) begin
                slip_d = 1'b1;
            end
            if (measuring) begin
                if (!cnt_sat) begin
                    prev_d      = cnt_q;
                    have_prev_d = 1'b1;
                end
                if (p_good) begin
                    period_d = cnt_q;
                    gen_ok_d = 1'b1;
                    if (good_q != GOOD_MAX) begin
                        good_d = good_q + 1'b1;
                    end
                    if ((state_q == ACQ) && (good_d == GOOD_MAX)) begin
                        state_d = LOCK;
                    end
                end else begin
                    good_d  = '0;
                    state_d = ACQ;
                end
            end else begin
                // IDLE or HOLD: this edge only starts a fresh measurement.
                have_prev_d = 1'b0;
                good_d      = '0;
                state_d     = ACQ;
            end
        end else begin
            if ((state_q != IDLE) && !cnt_sat) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (measuring && timeout) begin
                good_d = '0;
                if ((state_q == LOCK) && bus.holdover_en) begin
                    state_d = HOLD;
                end else begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    gen_ok_d    = 1'b0;
                    have_prev_d = 1'b0;
                end
            end
        end
    end

    assign gen_en = (state_d != IDLE) && gen_ok_d;

    wcm_phase_acc #(
        .DIVW (DIVW)
    ) u_phase_acc (
        .clk      (clk),
        .reset    (reset),
        .en       (gen_en),
        .restart  (restart),
        .p        (period_d),
        .n        (N_VAL),
        .strobe   (gen_strobe),
        .bitclock (gen_bitclock)
    );

    // Bit numbering: stop at the last bit in normal operation, wrap around in holdover.
    always_comb begin
        bit_strobe_d = 1'b0;
        bit_index_d  = bit_index_q;
        bitclock_d   = gen_bitclock;
        locked_d     = (state_d == LOCK);
        if (!gen_en) begin
            bit_index_d = '0;
        end else if (restart) begin
            bit_strobe_d = 1'b1;
            bit_index_d  = '0;
        end else if (gen_strobe) begin
            if (bit_index_q != IDX_LAST) begin
                bit_strobe_d = 1'b1;
                bit_index_d  = bit_index_q + 1'b1;
            end else if (state_d == HOLD) begin
                bit_strobe_d = 1'b1;
                bit_index_d  = '0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wc_d_q       <= 1'b0;
            cnt_q        <= '0;
            period_q     <= '0;
            prev_q       <= '0;
            have_prev_q  <= 1'b0;
            gen_ok_q     <= 1'b0;
            good_q       <= '0;
            bitclock_q   <= 1'b0;
            bit_strobe_q <= 1'b0;
            bit_index_q  <= '0;
            locked_q     <= 1'b0;
            slip_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wc_d_q       <= bus.wc;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            prev_q       <= prev_d;
            have_prev_q  <= have_prev_d;
            gen_ok_q     <= gen_ok_d;
            good_q       <= good_d;
            bitclock_q   <= bitclock_d;
            bit_strobe_q <= bit_strobe_d;
            bit_index_q  <= bit_index_d;
            locked_q     <= locked_d;
            slip_q       <= slip_d;
        end
    end

    assign bus.bitclock   = bitclock_q;
    assign bus.bit_strobe = bit_strobe_q;
    assign bus.bit_index  = bit_index_q;
    assign bus.locked     = locked_q;
    assign bus.period     = period_q;
    assign bus.slip       = slip_q;

endmodule

// File: tb/tb_word_clock_multiplier.sv
// Bench for word_clock_multiplier with MULTW=3 (8 bits per word).
// Latency: n/a.
// Backpressure: n/a.
module tb_word_clock_multiplier;
    import wcm_pkg::*;

    localparam int DIVW  = 16;
    localparam int MULTW = 3;
    localparam int TOL   = 4;
    localparam int LCNT  = 4;

    logic clk = 1'b0;
    logic reset;

    word_clock_multiplier_if #(.DIVW(DIVW), .MULTW(MULTW)) bus ();

    word_clock_multiplier #(
        .DIVW     (DIVW),
        .MULTW    (MULTW),
        .LOCK_TOL (TOL),
        .LOCK_CNT (LCNT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int per;        // wc period in clk cycles
        int exp_str;    // strobes in one word
        int exp_smin;   // min strobe spacing
        int exp_smax;   // max strobe spacing
        int exp_hi;     // bitclock-high cycles in one word
        int exp_lock;   // locked after 6 edges
        int exp_period; // period output after 6 edges
    } vec_t;

    vec_t vecs[6];

    int n_cmp = 0;
    int n_bad = 0;

    // monitor state
    bit mon_en = 1'b0;
    int t_now = 0;
    int s_cnt, s_last, s_min, s_max, hi_cnt, idx_err, slip_cnt;
    int err_cnt;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        s_cnt = 0; s_last = 0; s_min = 1000000; s_max = 0;
        hi_cnt = 0; idx_err = 0; slip_cnt = 0;
    endtask

    // One clk cycle with wc driven to w; outputs sampled 1 time unit after the edge.
    task automatic step(input logic w);
        bus.wc = w;
        @(posedge clk);
        #1;
        t_now++;
        if (bus.slip) slip_cnt++;
        if (mon_en) begin
            if (bus.bitclock) hi_cnt++;
            if (bus.bit_strobe) begin
                if (s_cnt > 0) begin
                    if (t_now - s_last < s_min) s_min = t_now - s_last;
                    if (t_now - s_last > s_max) s_max = t_now - s_last;
                end
                if (int'(bus.bit_index) != s_cnt) idx_err++;
                s_last = t_now;
                s_cnt++;
            end
        end
    endtask

    task automatic do_reset(input bit chk);
        reset = 1'b1;
        bus.holdover_en = 1'b0;
        step(1'b0);
        if (chk) begin
            check("rst_bitclock", bus.bitclock, 0);
            check("rst_strobe", bus.bit_strobe, 0);
            check("rst_index", bus.bit_index, 0);
            check("rst_locked", bus.locked, 0);
            check("rst_slip", bus.slip, 0);
            check("rst_period", bus.period, 0);
            check("rst_state", dut.state_q, IDLE);
        end
        step(1'b0);
        reset = 1'b0;
        repeat (3) step(1'b0);
        clear_stats();
    endtask

    // Five edges 80 cycles apart; returns right after the fifth edge sample.
    task automatic lock_up();
        for (int e = 0; e < 4; e++) begin
            step(1'b1);
            repeat (79) step(1'b0);
        end
        step(1'b1);
    endtask

    int exp_i;
    bit exp_s;

    initial begin
        reset = 1'b1;
        bus.wc = 1'b0;
        bus.holdover_en = 1'b0;

        vecs[0] = '{per: 80,  exp_str: 8, exp_smin: 10, exp_smax: 10, exp_hi: 40, exp_lock: 1, exp_period: 80};
        vecs[1] = '{per: 84,  exp_str: 8, exp_smin: 10, exp_smax: 11, exp_hi: 44, exp_lock: 1, exp_period: 84};
        vecs[2] = '{per: 96,  exp_str: 8, exp_smin: 12, exp_smax: 12, exp_hi: 48, exp_lock: 1, exp_period: 96};
        vecs[3] = '{per: 100, exp_str: 8, exp_smin: 12, exp_smax: 13, exp_hi: 52, exp_lock: 1, exp_period: 100};
        vecs[4] = '{per: 8,   exp_str: 8, exp_smin: 1,  exp_smax: 1,  exp_hi: 8,  exp_lock: 1, exp_period: 8};
        vecs[5] = '{per: 7,   exp_str: 0, exp_smin: 0,  exp_smax: 0,  exp_hi: 0,  exp_lock: 0, exp_period: 0};

        do_reset(1'b1);

        // Steady-rate vectors: measure the word between edge 5 and edge 6.
        for (int v = 0; v < 6; v++) begin
            do_reset(1'b0);
            for (int e = 1; e <= 6; e++) begin
                if (e == 5) mon_en = 1'b1;
                if (e == 6) mon_en = 1'b0;
                step(1'b1);
                if (e < 6) repeat (vecs[v].per - 1) step(1'b0);
            end
            check($sformatf("v%0d_strobes", vecs[v].per), s_cnt, vecs[v].exp_str);
            check($sformatf("v%0d_spacing_min", vecs[v].per), (s_cnt > 1) ? s_min : 0, vecs[v].exp_smin);
            check($sformatf("v%0d_spacing_max", vecs[v].per), s_max, vecs[v].exp_smax);
            check($sformatf("v%0d_bitclk_hi", vecs[v].per), hi_cnt, vecs[v].exp_hi);
            check($sformatf("v%0d_index_seq_err", vecs[v].per), idx_err, 0);
            check($sformatf("v%0d_slips", vecs[v].per), slip_cnt, 0);
            check($sformatf("v%0d_locked", vecs[v].per), bus.locked, vecs[v].exp_lock);
            check($sformatf("v%0d_period", vecs[v].per), bus.period, vecs[v].exp_period);
        end

        // Lock after the fifth edge, unlock on a 90-cycle period.
        do_reset(1'b0);
        for (int e = 1; e <= 5; e++) begin
            step(1'b1);
            if (e == 4) check("lock_after_e4", bus.locked, 0);
            if (e == 5) check("lock_after_e5", bus.locked, 1);
            if (e < 5) repeat (79) step(1'b0);
        end
        repeat (89) step(1'b0);
        step(1'b1);
        check("unlock_p90_locked", bus.locked, 0);
        check("unlock_p90_state", dut.state_q, ACQ);
        check("unlock_p90_period", bus.period, 80);

        // Holdover: wc stops after lock, generation continues with wrapping index.
        do_reset(1'b0);
        bus.holdover_en = 1'b1;
        lock_up();
        err_cnt = 0;
        for (int k = 1; k <= 260; k++) begin
            step(1'b0);
            exp_s = (k % 10 == 0) && ((k <= 70) || (k >= 170));
            if (bus.bit_strobe !== exp_s) err_cnt++;
            if (exp_s && bus.bit_strobe) begin
                exp_i = (k <= 70) ? k / 10 : ((k - 170) / 10) % 8;
                if (int'(bus.bit_index) != exp_i) err_cnt++;
            end
            if (bus.bitclock !== ((k % 10) < 5)) err_cnt++;
            if (k == 160) check("hold_locked_k160", bus.locked, 1);
            if (k == 161) begin
                check("hold_locked_k161", bus.locked, 0);
                check("hold_state_k161", dut.state_q, HOLD);
            end
        end
        check("hold_sequence_err", err_cnt, 0);
        step(1'b1);
        check("hold_edge_state", dut.state_q, ACQ);
        check("hold_edge_index", bus.bit_index, 0);
        check("hold_edge_strobe", bus.bit_strobe, 1);

        // Loss of wc without holdover: everything returns to idle.
        do_reset(1'b0);
        lock_up();
        err_cnt = 0;
        for (int k = 1; k <= 200; k++) begin
            step(1'b0);
            if (k == 160) check("nohold_locked_k160", bus.locked, 1);
            if (k == 161) check("nohold_state_k161", dut.state_q, IDLE);
            if (k >= 161) begin
                if (bus.bitclock || bus.bit_strobe || bus.locked || bus.slip ||
                    (bus.bit_index != 0)) err_cnt++;
            end
        end
        check("nohold_outputs_err", err_cnt, 0);

        // Early edge halfway through a word.
        do_reset(1'b0);
        lock_up();
        slip_cnt = 0;
        repeat (39) step(1'b0);
        check("slip_index_before", bus.bit_index, 3);
        step(1'b1);
        check("slip_pulse", bus.slip, 1);
        check("slip_index_restart", bus.bit_index, 0);
        check("slip_strobe", bus.bit_strobe, 1);
        step(1'b0);
        check("slip_one_cycle", bus.slip, 0);
        check("slip_count", slip_cnt, 1);
        check("slip_unlocked", bus.locked, 0);

        // Reset mid-word while locked, then relock from scratch.
        do_reset(1'b0);
        lock_up();
        repeat (30) step(1'b0);
        reset = 1'b1;
        step(1'b0);
        check("midrst_bitclock", bus.bitclock, 0);
        check("midrst_strobe", bus.bit_strobe, 0);
        check("midrst_index", bus.bit_index, 0);
        check("midrst_locked", bus.locked, 0);
        check("midrst_slip", bus.slip, 0);
        check("midrst_period", bus.period, 0);
        reset = 1'b0;
        step(1'b0);
        for (int e = 1; e <= 5; e++) begin
            step(1'b1);
            if (e == 1) check("relock_e1_strobe", bus.bit_strobe, 0);
            if (e == 4) check("relock_e4", bus.locked, 0);
            if (e == 5) check("relock_e5", bus.locked, 1);
            if (e < 5) repeat (79) step(1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/word_clock_multiplier.md
WORD_CLOCK_MULTIPLIER -- requirements
Module: word_clock_multiplier

Interface
REQ-001 SHALL have parameter DIVW, default 16: period counter width is DIVW+1 bits.
REQ-002 SHALL have parameter MULTW, default 8: bits per word N = 2^MULTW.
REQ-003 SHALL have parameter LOCK_TOL, default 4: allowed period deviation in clk cycles, word to word.
REQ-004 SHALL have parameter LOCK_CNT, default 4: consecutive good periods needed to lock.
REQ-005 SHALL have one clock; reset is synchronous and active-high: clk  in  1  sole clock.
REQ-006 SHALL have port reset  in  1  synchronous, active-high.
REQ-007 SHALL have port wc  in  1  word clock, synchronous to clk.
REQ-008 SHALL have port holdover_en  in  1  free-run on last period when wc is lost.
REQ-009 SHALL have port bitclock  out  1  ~50% duty bit clock.
REQ-010 SHALL have port bit_strobe  out  1  one-cycle pulse at the start of each bit.
REQ-011 SHALL have port bit_index  out  MULTW  index of the current bit.
REQ-012 SHALL have port locked  out  1  lock indicator.
REQ-013 SHALL have port period  out  DIVW+1  last accepted word period, in clk cycles.
REQ-014 SHALL have port slip  out  1  one-cycle pulse when a word edge arrives before N strobes.

Function
REQ-015 SHALL register wc into wc_d; edge = wc & ~wc_d; P = clk cycles between consecutive edges.
REQ-016 SHALL saturate the period counter at all-ones; a saturated count counts as a bad period.
REQ-017 SHALL, in the edge cycle: latch P into period, clear the accumulator, set bit_index=0, and pulse bit_strobe in the next cycle (latency 1).
REQ-018 SHALL, each subsequent cycle, add N to the DIVW+1-bit accumulator; when acc+N >= P, subtract P, pulse bit_strobe and increment bit_index. This yields exactly N evenly spread strobes per word, with spacing floor(P/N) or ceil(P/N).
REQ-019 SHALL drive bitclock=1 while acc < P>>1, and 0 otherwise.
REQ-020 SHALL hold bit_index at N-1 and suppress further strobes until the next edge (non-holdover).
REQ-021 SHALL pulse slip when an edge arrives while bit_index < N-1 (only after the first period has been measured).
REQ-022 SHALL treat a period as good iff P >= N, it is unsaturated, and |P - previous P| <= LOCK_TOL.
REQ-023 SHALL implement the FSM states IDLE, ACQ, LOCK, HOLD with these transitions:
- IDLE -> ACQ on the first edge.
- ACQ -> LOCK after LOCK_CNT consecutive good periods.
- ACQ/LOCK -> ACQ on a bad period, with the good-period count cleared.
- LOCK -> HOLD when the counter exceeds 2P and holdover_en=1.
- LOCK/ACQ -> IDLE when the counter exceeds 2P and holdover_en=0.
- HOLD -> ACQ on an edge.
REQ-024 SHALL assert locked only in LOCK; it drops in the same cycle the FSM leaves LOCK.
REQ-025 SHALL, in HOLD, keep generating with the latched P and wrap bit_index from N-1 to 0 (strobe included).
REQ-026 SHALL force bitclock=0, bit_strobe=0 and bit_index=0 in IDLE.
REQ-027 SHALL process an edge before a timeout when both occur in the same cycle.
REQ-028 SHALL perform all arithmetic unsigned with a DIVW+1-bit accumulator; P < N is never used for generation (bad period, no strobes).

Reset
REQ-029 SHALL, on reset=1 at a clk edge, set: FSM=IDLE, accumulator=0, period counter=0, period=0, good count=0, wc_d=0.
REQ-030 SHALL, on reset, set outputs: bitclock=0, bit_strobe=0, bit_index=0, locked=0, slip=0.
REQ-031 SHALL, on reset mid-word, discard the partial measurement; the first edge after release only starts measurement.

Structure
REQ-032 SHALL place the FSM state typedef (IDLE/ACQ/LOCK/HOLD) and the parameter defaults in shared package wcm_pkg.
REQ-033 SHALL implement the accumulator/strobe generator as sub-module wcm_phase_acc (inputs P, N, restart; outputs strobe, bitclock).
REQ-034 SHALL keep the FSM, period measurement and lock logic in the top module.

Verification
REQ-035 SHALL cover: MULTW=3, wc period 80 -> strobes every 10 cycles, 8 per word, bit_index 0..7, bitclock high 5 cycles per bit.
REQ-036 SHALL cover: MULTW=3, period 84 -> 8 strobes per word, spacings only 10/11, sum 84, no slip.
REQ-037 SHALL cover: 5 edges at period 80 (LOCK_CNT=4) -> locked rises after the 5th edge; a next period of 90 (tol 4) -> locked=0, FSM=ACQ.
REQ-038 SHALL cover: locked, then wc stopped with holdover_en=1 -> locked falls at count 161, strobes continue every 10 cycles with bit_index wrapping; with holdover_en=0 -> outputs 0, FSM=IDLE.
REQ-039 SHALL cover: period 80, then one early edge at 40 -> slip pulses once, bit_index restarts at 0.
REQ-040 SHALL cover: reset asserted mid-word while locked -> all outputs 0 next cycle; relock needs LOCK_CNT+1 fresh edges.
